// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: merges pipeline results with
// buffered long-latency results and tracks pending long-latency writes per register.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned LAT_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_dest,
  output logic                  iss_block,
  input  logic                  pipe_wen,
  input  logic [4:0]            pipe_waddr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  input  logic                  lat_valid,
  input  logic [4:0]            lat_waddr,
  input  logic [DATA_WIDTH-1:0] lat_wdata,
  output logic                  lat_ready,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [4:0]            waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  WEN,
  output logic                  err
);

  localparam int unsigned PW = (LAT_DEPTH > 1) ? $clog2(LAT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(LAT_DEPTH + 1);

  logic [31:0]           busy_q, busy_d;
  logic [4:0]            fifo_addr_q [LAT_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [LAT_DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  err_q;

  logic                  fifo_empty, fifo_full;
  logic                  lat_accept, lat_live;
  logic                  sel_pipe, sel_pop, sel_byp, push;
  logic                  lat_wr;
  logic [4:0]            lat_wr_addr;
  logic [DATA_WIDTH-1:0] lat_wr_data;
  logic                  iss_set, err_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LAT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(LAT_DEPTH));

  // Ready is judged on the pre-pop occupancy, so a full FIFO refuses even when it pops.
  assign lat_ready  = !RST && !fifo_full;
  assign lat_accept = lat_valid && lat_ready;
  assign lat_live   = lat_accept && (lat_waddr != 5'd0);

  assign sel_pipe = !RST && pipe_wen;
  assign sel_pop  = !RST && !pipe_wen && !fifo_empty;
  assign sel_byp  = !RST && !pipe_wen && fifo_empty && lat_live;
  assign push     = lat_live && !sel_byp;

  assign lat_wr      = sel_pop || sel_byp;
  assign lat_wr_addr = sel_pop ? fifo_addr_q[rd_ptr_q] : lat_waddr;
  assign lat_wr_data = sel_pop ? fifo_data_q[rd_ptr_q] : lat_wdata;

  assign WEN   = sel_pipe || lat_wr;
  assign waddr = sel_pipe ? pipe_waddr : lat_wr_addr;
  assign wdata = sel_pipe ? pipe_wdata : lat_wr_data;

  assign iss_block = (iss_dest != 5'd0) && busy_q[iss_dest];
  assign iss_set   = iss_valid && (iss_dest != 5'd0) && !busy_q[iss_dest];
  assign err_set   = (iss_valid && iss_block) || (lat_live && !busy_q[lat_waddr]);

  // The register file forwards the port write, so a retiring register no longer stalls.
  assign hazard1 = (raddr1 != 5'd0) && busy_q[raddr1] && !(lat_wr && lat_wr_addr == raddr1);
  assign hazard2 = (raddr2 != 5'd0) && busy_q[raddr2] && !(lat_wr && lat_wr_addr == raddr2);

  assign err = err_q;

  always_comb begin
    busy_d = busy_q;
    if (lat_wr) busy_d[lat_wr_addr] = 1'b0;
    if (iss_set) busy_d[iss_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (err_set) err_q <= 1'b1;
      if (sel_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      unique case ({push, sel_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= lat_waddr;
      fifo_data_q[wr_ptr_q] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected port writes are queued in required port
// order and checked whenever WEN is seen; control outputs are checked inline.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic        iss_block;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lat_valid;
  logic [4:0]  lat_waddr;
  logic [31:0] lat_wdata;
  logic        lat_ready;
  logic [4:0]  raddr1, raddr2;
  logic        hazard1, hazard2;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        WEN;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter #(.DATA_WIDTH(32), .LAT_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_block(iss_block),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lat_valid(lat_valid), .lat_waddr(lat_waddr), .lat_wdata(lat_wdata),
    .lat_ready(lat_ready),
    .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
    .waddr(waddr), .wdata(wdata), .WEN(WEN), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_dest = 5'd0;
    pipe_wen = 1'b0; pipe_waddr = 5'd0; pipe_wdata = '0;
    lat_valid = 1'b0; lat_waddr = 5'd0; lat_wdata = '0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_wen = 1'b1; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic lat(input logic [4:0] a, input logic [31:0] d);
    lat_valid = 1'b1; lat_waddr = a; lat_wdata = d;
  endtask

  task automatic issue(input logic [4:0] a);
    iss_valid = 1'b1; iss_dest = a;
  endtask

  // Scoreboard sample on the falling edge, then advance past the next rising edge.
  task automatic tick();
    logic [36:0] e;
    @(negedge CLK);
    if (WEN) begin
      if (exp_q.size() == 0) chk("sb_extra_write", 64'(WEN), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_write", 64'({waddr, wdata}), 64'(e));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    raddr1 = 5'd0; raddr2 = 5'd0;
    RST = 1'b1;
    pipe(5'd7, 32'h1);
    lat(5'd5, 32'h2);
    @(posedge CLK); #1;
    raddr1 = 5'd5; iss_dest = 5'd5;
    chk("rst_wen", 64'(WEN), 64'd0);
    chk("rst_lat_ready", 64'(lat_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_hazard1", 64'(hazard1), 64'd0);
    tick();
    RST = 1'b0; idle();
    #1 chk("post_rst_ready", 64'(lat_ready), 64'd1);

    // Issue r5 then bypass its result.
    issue(5'd5); tick(); idle();
    iss_dest = 5'd5; raddr1 = 5'd5;
    #1 chk("busy5_block", 64'(iss_block), 64'd1);
    chk("busy5_hazard", 64'(hazard1), 64'd1);
    tick(); tick();
    lat(5'd5, 32'hDEAD); exp_q.push_back({5'd5, 32'hDEAD});
    #1 chk("byp_wen", 64'(WEN), 64'd1);
    chk("byp_waddr", 64'(waddr), 64'd5);
    chk("byp_hazard_exc", 64'(hazard1), 64'd0);
    chk("byp_err", 64'(err), 64'd0);
    tick(); idle(); raddr1 = 5'd5; iss_dest = 5'd5;
    #1 chk("byp_busy_clr", 64'(hazard1), 64'd0);
    chk("byp_block_clr", 64'(iss_block), 64'd0);

    // Contention: pipeline writes take the port ahead of buffered results.
    issue(5'd3); tick(); issue(5'd4); tick(); idle();
    raddr1 = 5'd3; raddr2 = 5'd4;
    lat(5'd3, 32'h11); pipe(5'd7, 32'h77); exp_q.push_back({5'd7, 32'h77});
    #1 chk("cont_ready0", 64'(lat_ready), 64'd1);
    chk("cont_haz_r3_a", 64'(hazard1), 64'd1);
    tick();
    lat(5'd4, 32'h22); pipe(5'd8, 32'h88); exp_q.push_back({5'd8, 32'h88});
    #1 chk("cont_ready1", 64'(lat_ready), 64'd1);
    chk("cont_haz_r3_b", 64'(hazard1), 64'd1);
    tick(); idle();
    exp_q.push_back({5'd3, 32'h11});
    #1 chk("cont_full_ready", 64'(lat_ready), 64'd0);
    chk("cont_haz_r3_wr", 64'(hazard1), 64'd0);
    chk("cont_haz_r4_wait", 64'(hazard2), 64'd1);
    tick();
    exp_q.push_back({5'd4, 32'h22});
    #1 chk("cont_haz_r3_done", 64'(hazard1), 64'd0);
    chk("cont_haz_r4_wr", 64'(hazard2), 64'd0);
    tick();
    #1 chk("cont_idle_wen", 64'(WEN), 64'd0);

    // Full FIFO: pop and refused push in the same cycle.
    issue(5'd10); tick(); issue(5'd11); tick(); issue(5'd12); tick(); idle();
    pipe(5'd1, 32'hA1); lat(5'd10, 32'h100); exp_q.push_back({5'd1, 32'hA1});
    tick();
    pipe(5'd2, 32'hA2); lat(5'd11, 32'h110); exp_q.push_back({5'd2, 32'hA2});
    tick(); idle();
    lat(5'd12, 32'h120); exp_q.push_back({5'd10, 32'h100});
    #1 chk("full_ready", 64'(lat_ready), 64'd0);
    chk("full_pop_addr", 64'(waddr), 64'd10);
    tick();
    exp_q.push_back({5'd11, 32'h110});
    #1 chk("full_accept_next", 64'(lat_ready), 64'd1);
    tick(); idle();
    exp_q.push_back({5'd12, 32'h120});
    tick();
    #1 chk("full_drained", 64'(WEN), 64'd0);
    chk("err_clean", 64'(err), 64'd0);

    // Illegal re-issue of a busy register.
    issue(5'd9); tick();
    issue(5'd9); raddr1 = 5'd9;
    #1 chk("ill_block", 64'(iss_block), 64'd1);
    tick(); idle(); iss_dest = 5'd9;
    #1 chk("ill_err", 64'(err), 64'd1);
    chk("ill_haz", 64'(hazard1), 64'd1);
    tick();
    lat(5'd9, 32'h99); exp_q.push_back({5'd9, 32'h99});
    #1 chk("ill_err_sticky", 64'(err), 64'd1);
    tick(); idle(); iss_dest = 5'd9;
    #1 chk("ill_single_clr", 64'(hazard1), 64'd0);
    chk("ill_block_clr", 64'(iss_block), 64'd0);

    // r0 result dropped; r0 pipeline write passed through.
    lat(5'd0, 32'h5);
    #1 chk("r0_no_wen", 64'(WEN), 64'd0);
    chk("r0_ready", 64'(lat_ready), 64'd1);
    tick(); idle();
    #1 chk("r0_no_push", 64'(WEN), 64'd0);
    pipe(5'd0, 32'h33); exp_q.push_back({5'd0, 32'h33});
    tick(); idle();

    // Same-cycle set and clear of r6: the set wins.
    issue(5'd6); lat(5'd6, 32'h66); exp_q.push_back({5'd6, 32'h66}); raddr1 = 5'd6;
    tick(); idle(); iss_dest = 5'd6;
    #1 chk("sc_haz", 64'(hazard1), 64'd1);
    chk("sc_block", 64'(iss_block), 64'd1);
    lat(5'd6, 32'h67); exp_q.push_back({5'd6, 32'h67});
    tick(); idle();
    #1 chk("sc_cleared", 64'(hazard1), 64'd0);

    // Reset mid-operation discards a buffered result.
    issue(5'd13); tick(); idle();
    pipe(5'd1, 32'hB1); lat(5'd13, 32'h130); exp_q.push_back({5'd1, 32'hB1});
    tick(); idle();
    RST = 1'b1; raddr1 = 5'd13;
    #1 chk("mid_rst_wen", 64'(WEN), 64'd0);
    chk("mid_rst_ready", 64'(lat_ready), 64'd0);
    tick();
    RST = 1'b0;
    #1 chk("mid_rst_discard", 64'(WEN), 64'd0);
    chk("mid_rst_busy", 64'(hazard1), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    tick();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
